// File: rtl/norm32_pkg.sv
// Shared types and constants for the sequential 32-bit normaliser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package norm32_pkg;

    // One state per binary-search step, plus idle and result-hold states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S16  = 3'd1,
        ST_S8   = 3'd2,
        ST_S4   = 3'd3,
        ST_S2   = 3'd4,
        ST_S1   = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [4:0] STEP_16 = 5'd16;
    localparam logic [4:0] STEP_8  = 5'd8;
    localparam logic [4:0] STEP_4  = 5'd4;
    localparam logic [4:0] STEP_2  = 5'd2;
    localparam logic [4:0] STEP_1  = 5'd1;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Shift width examined in each search state; zero outside the search.
    function automatic logic [4:0] step_width(input state_t s);
        logic [4:0] k;
        k = 5'd0;
        case (s)
            ST_S16:  k = STEP_16;
            ST_S8:   k = STEP_8;
            ST_S4:   k = STEP_4;
            ST_S2:   k = STEP_2;
            ST_S1:   k = STEP_1;
            default: k = 5'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/norm_step.sv
// One binary-search step: tests whether the top k bits are redundant and offers x << k.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module norm_step
    import norm32_pkg::*;
(
    input  logic [31:0] x,
    input  logic [4:0]  k,
    input  logic        mode,
    output logic        redundant,
    output logic [31:0] x_shifted
);

    logic [31:0] mask_u;
    logic [31:0] mask_s;
    logic [5:0]  k_plus1;

    // Unsigned looks at the top k bits; signed needs the top k+1 bits to agree
    // so the sign bit survives the shift.
    assign k_plus1   = {1'b0, k} + 6'd1;
    assign mask_u    = ~(32'hFFFF_FFFF >> k);
    assign mask_s    = ~(32'hFFFF_FFFF >> k_plus1);
    assign redundant = (mode == MODE_SIGNED) ?
                       (((x ^ {32{x[31]}}) & mask_s) == 32'd0) :
                       ((x & mask_u) == 32'd0);
    assign x_shifted = x << k;

endmodule

// File: rtl/norm32_seq.sv
// Sequential normaliser: returns a << cnt where cnt is the leading-zero / redundant-sign count.
// Latency: accept edge, five search edges, result held from the cycle after the fifth step.
// Backpressure: result held in DONE until out_ready; no new operand accepted until then.
module norm32_seq
    import norm32_pkg::*;
(
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [5:0]  cnt,
    output logic        zero
);

    state_t      state;
    logic [31:0] x_r;
    logic [5:0]  cnt_r;
    logic        zero_r;
    logic        mode_r;

    logic [4:0]  k;
    logic        step_red;
    logic [31:0] step_x;

    assign k = step_width(state);

    norm_step u_step (
        .x         (x_r),
        .k         (k),
        .mode      (mode_r),
        .redundant (step_red),
        .x_shifted (step_x)
    );

    // Search FSM with working value, count accumulator and zero latch.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state  <= ST_IDLE;
            x_r    <= 32'd0;
            cnt_r  <= 6'd0;
            zero_r <= 1'b0;
            mode_r <= MODE_UNSIGNED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r    <= a;
                        cnt_r  <= 6'd0;
                        mode_r <= mode;
                        zero_r <= (a == 32'd0);
                        state  <= ST_S16;
                    end
                end
                ST_S16, ST_S8, ST_S4, ST_S2: begin
                    if (step_red) begin
                        x_r   <= step_x;
                        cnt_r <= cnt_r + {1'b0, k};
                    end
                    state <= state_t'(state + 3'd1);
                end
                ST_S1: begin
                    // An unsigned zero operand reports a full-width count of 32.
                    if (zero_r && (mode_r == MODE_UNSIGNED)) begin
                        x_r   <= 32'd0;
                        cnt_r <= 6'd32;
                    end else if (step_red) begin
                        x_r   <= step_x;
                        cnt_r <= cnt_r + {1'b0, k};
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign z         = x_r;
    assign cnt       = cnt_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_norm32_seq.sv
// Self-checking bench for norm32_seq: directed corner cases, handshake, reset, random sweep.
// Latency: n/a.
// Backpressure: exercises held results and back-to-back operation.
module tb_norm32_seq;

    logic        sys_clk;
    logic        resetl;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [5:0]  cnt;
    logic        zero;

    int total;
    int bad;

    norm32_seq dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .cnt       (cnt),
        .zero      (zero)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: count leading zeros (unsigned) or bits matching the sign bit below it (signed).
    function automatic void ref_norm(input logic m, input logic [31:0] v,
                                     output logic [5:0] c, output logic [31:0] zz,
                                     output logic zr);
        int n;
        n = 0;
        if (m == 1'b0) begin
            while (n < 32 && v[31-n] == 1'b0) n++;
        end else begin
            while (n < 31 && v[30-n] == v[31]) n++;
        end
        c  = 6'(n);
        zz = (n >= 32) ? 32'd0 : (v << n);
        zr = (v == 32'd0);
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (!in_ready) chk({tag, "_idle_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // One full transaction; optional latency check, busy-time garbage, and hold cycles.
    task automatic do_op(input string tag, input logic m, input logic [31:0] v,
                         input bit chk_lat, input bit garble, input int hold);
        logic [5:0]  ec;
        logic [31:0] ez;
        logic        ezr;
        int          n;
        ref_norm(m, v, ec, ez, ezr);
        wait_idle(tag);
        in_valid = 1'b1;
        mode     = m;
        a        = v;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (garble && n < 3) begin
                in_valid = 1'($urandom);
                mode     = 1'($urandom);
                a        = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge sys_clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!out_valid) chk({tag, "_done_timeout"}, 32'(out_valid), 32'd1);
        if (chk_lat) chk({tag, "_latency"}, 32'(n), 32'd5);
        for (int h = 0; h < hold; h++) begin
            @(posedge sys_clk); #1;
            chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_z"}, z, ez);
            chk({tag, "_hold_cnt"}, 32'(cnt), 32'(ec));
        end
        chk({tag, "_z"}, z, ez);
        chk({tag, "_cnt"}, 32'(cnt), 32'(ec));
        chk({tag, "_zero"}, 32'(zero), 32'(ezr));
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        out_ready = 1'b0;
        if (hold > 0) begin
            chk({tag, "_drop_vld"}, 32'(out_valid), 32'd0);
            chk({tag, "_back_rdy"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int acc[$];
        total     = 0;
        bad       = 0;
        resetl    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        a         = 32'd0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", z, 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge sys_clk);
        resetl = 1'b1;
        @(posedge sys_clk); #1;

        // Directed corners.
        do_op("u_one",   1'b0, 32'h0000_0001, 1'b1, 1'b0, 1);
        do_op("u_zero",  1'b0, 32'h0000_0000, 1'b1, 1'b0, 1);
        do_op("s_zero",  1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);
        do_op("s_ones",  1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op("s_ff00",  1'b1, 32'hFFFF_FF00, 1'b0, 1'b0, 0);
        do_op("s_1234",  1'b1, 32'h0000_1234, 1'b0, 1'b0, 0);
        do_op("u_msb",   1'b0, 32'h8000_0000, 1'b0, 1'b0, 0);
        do_op("s_pos1",  1'b1, 32'h4000_0000, 1'b0, 1'b0, 0);
        do_op("s_neg",   1'b1, 32'h8000_0000, 1'b0, 1'b0, 0);

        // Result held under backpressure, busy-time input noise ignored.
        do_op("hold10",  1'b0, 32'h0001_2345, 1'b1, 1'b0, 10);
        do_op("garble",  1'b1, 32'hFFF0_1234, 1'b1, 1'b1, 2);

        // Back-to-back with both sides always willing.
        wait_idle("b2b");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = 1'b0;
        a         = 32'h0000_00F0;
        for (int c = 0; c < 22; c++) begin
            @(negedge sys_clk);
            if (in_ready) acc.push_back(c);
            @(posedge sys_clk);
        end
        #1;
        in_valid = 1'b0;
        chk("b2b_count", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd7);
            chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd7);
        end
        wait_idle("b2b_end");
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a search.
        in_valid = 1'b1;
        mode     = 1'b0;
        a        = 32'h0000_0003;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk); #3;
        resetl = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_z", z, 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd0);
        @(negedge sys_clk);
        resetl = 1'b1;
        @(posedge sys_clk); #1;
        do_op("post_rst", 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 0);

        // Random sweep; random shift keeps a spread of leading-bit counts.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] v;
            logic        m;
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v;
            if ($urandom_range(0, 63) == 0) v = 32'd0;
            m = 1'($urandom);
            do_op("rand", m, v, 1'b0, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
